// File: rtl/minmax_stream_tracker_if.sv
// Valid/ready stream bundle for minmax_stream_tracker: sample input side and result output side.
// IDXW is derived from COUNT so the index width always matches the tracker.
interface minmax_stream_tracker_if #(
  parameter int WIDTH = 2,
  parameter int COUNT = 4
);
  localparam int IDXW = $clog2(COUNT);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_index;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index
  );
endinterface

// File: rtl/minmax_stream_tracker.sv
// Serial min/max tracker: takes COUNT samples per frame, returns the extreme value and its index.
// Optional macro MINMAX_TIE_LAST_EN makes ties report the latest position instead of the earliest.
module minmax_stream_tracker #(
  parameter int WIDTH = 2,
  parameter     TYPE  = "minsel",
  parameter int COUNT = 4
) (
  input logic                   clk,
  input logic                   rst,
  minmax_stream_tracker_if.slave bus
);
  localparam int IDXW   = $clog2(COUNT);
  localparam bit IS_MIN = (TYPE == "minsel");

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] best;
  logic [IDXW-1:0]  best_idx;
  logic [IDXW-1:0]  count;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IDXW-1:0]  out_index_q;

  logic             accept;
  logic             better;
  logic [WIDTH-1:0] nxt_best;
  logic [IDXW-1:0]  nxt_idx;

  assign accept        = bus.in_valid && in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;

  always_comb begin
    better = 1'b0;
`ifdef MINMAX_TIE_LAST_EN
    if (IS_MIN) better = (bus.in_data <= best);
    else        better = (bus.in_data >= best);
`else
    if (IS_MIN) better = (bus.in_data < best);
    else        better = (bus.in_data > best);
`endif
    nxt_best = better ? bus.in_data : best;
    nxt_idx  = better ? count : best_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      best        <= '0;
      best_idx    <= '0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            best     <= bus.in_data;
            best_idx <= '0;
            count    <= IDXW'(1);
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            best     <= nxt_best;
            best_idx <= nxt_idx;
            // Last sample's comparison is folded straight into the registered result.
            if (count == IDXW'(COUNT - 1)) begin
              state       <= HOLD;
              count       <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= nxt_best;
              out_index_q <= nxt_idx;
            end else begin
              count <= count + IDXW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            count       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_minmax_stream_tracker.sv
// Scoreboard bench: minsel and maxsel trackers share one stimulus stream; a frame-level model
// predicts handshakes and results, a negedge monitor compares against queued expectations.
module tb_minmax_stream_tracker;
  localparam int WIDTH = 2;
  localparam int COUNT = 4;
  localparam int IDXW  = $clog2(COUNT);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  typedef struct { logic [WIDTH-1:0] data; logic [IDXW-1:0] idx; } result_t;
  result_t exp_min[$];
  result_t exp_max[$];
  logic [WIDTH-1:0] frame[$];
  bit mhold = 1'b0;

  always #5 clk = ~clk;

  minmax_stream_tracker_if #(.WIDTH(WIDTH), .COUNT(COUNT)) if_min ();
  minmax_stream_tracker_if #(.WIDTH(WIDTH), .COUNT(COUNT)) if_max ();

  assign if_min.in_valid  = in_valid;
  assign if_min.in_data   = in_data;
  assign if_min.out_ready = out_ready;
  assign if_max.in_valid  = in_valid;
  assign if_max.in_data   = in_data;
  assign if_max.out_ready = out_ready;

  minmax_stream_tracker #(.WIDTH(WIDTH), .TYPE("minsel"), .COUNT(COUNT)) dut_min (
    .clk(clk), .rst(rst), .bus(if_min.slave));
  minmax_stream_tracker #(.WIDTH(WIDTH), .TYPE("maxsel"), .COUNT(COUNT)) dut_max (
    .clk(clk), .rst(rst), .bus(if_max.slave));

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Extreme value of a frame, then the first (or last, with tie-last) position holding it.
  function automatic result_t model(input logic [WIDTH-1:0] f[$], input bit want_min);
    result_t r;
    int ext = int'(f[0]);
    foreach (f[i]) begin
      if (want_min ? (int'(f[i]) < ext) : (int'(f[i]) > ext)) ext = int'(f[i]);
    end
    r.data = WIDTH'(ext);
    r.idx  = '0;
`ifdef MINMAX_TIE_LAST_EN
    foreach (f[i]) if (int'(f[i]) == ext) r.idx = IDXW'(i);
`else
    for (int i = f.size() - 1; i >= 0; i--) if (int'(f[i]) == ext) r.idx = IDXW'(i);
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      frame.delete();
      exp_min.delete();
      exp_max.delete();
      mhold = 1'b0;
    end else if (mhold) begin
      if (out_ready) mhold = 1'b0;
    end else if (in_valid) begin
      frame.push_back(in_data);
      if (frame.size() == COUNT) begin
        exp_min.push_back(model(frame, 1'b1));
        exp_max.push_back(model(frame, 1'b0));
        frame.delete();
        mhold = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("min_in_ready",  int'(if_min.in_ready),  int'(!mhold));
      check("max_in_ready",  int'(if_max.in_ready),  int'(!mhold));
      check("min_out_valid", int'(if_min.out_valid), int'(mhold));
      check("max_out_valid", int'(if_max.out_valid), int'(mhold));
      if (if_min.out_valid) begin
        if (exp_min.size() == 0) check("min_unexpected_result", 1, 0);
        else begin
          check("min_out_data",  int'(if_min.out_data),  int'(exp_min[0].data));
          check("min_out_index", int'(if_min.out_index), int'(exp_min[0].idx));
          if (out_ready) void'(exp_min.pop_front());
        end
      end
      if (if_max.out_valid) begin
        if (exp_max.size() == 0) check("max_unexpected_result", 1, 0);
        else begin
          check("max_out_data",  int'(if_max.out_data),  int'(exp_max[0].data));
          check("max_out_index", int'(if_max.out_index), int'(exp_max[0].idx));
          if (out_ready) void'(exp_max.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int d, input bit r);
    in_valid  = v;
    in_data   = WIDTH'(d);
    out_ready = r;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_min_data"},  int'(if_min.out_data),  0);
    check({tag, "_min_index"}, int'(if_min.out_index), 0);
    check({tag, "_max_data"},  int'(if_max.out_data),  0);
    check({tag, "_max_index"}, int'(if_max.out_index), 0);
  endtask

  initial begin
    int gap_v[7] = '{1, 0, 0, 1, 0, 1, 1};
    int gap_d[7] = '{2, 0, 3, 2, 1, 3, 1};
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    check_reset_outputs("reset");

    // 3,1,2,0: min 0@3, max 3@0
    foreach (gap_v[i]) ; // keep arrays referenced before first use
    drive(1, 3, 1); drive(1, 1, 1); drive(1, 2, 1); drive(1, 0, 1);
    drive(0, 0, 1); drive(0, 0, 1);

    // 1,3,0,3: max 3@1 (3@3 with tie-last), min 0@2
    drive(1, 1, 1); drive(1, 3, 1); drive(1, 0, 1); drive(1, 3, 1);
    drive(0, 0, 1);

    // Gapped input: accepted samples 2,2,3,1
    foreach (gap_v[i]) drive(gap_v[i][0], gap_d[i], 1);
    drive(0, 0, 1);

    // Backpressure: hold the result for 5 cycles with the producer still pushing
    drive(1, 2, 0); drive(1, 1, 0); drive(1, 3, 0); drive(1, 2, 0);
    for (int i = 0; i < 5; i++) drive(1, 3, 0);
    drive(1, 0, 1);
    drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 1);
    drive(0, 0, 1);

    // Reset mid-frame, then 1,3,3,2
    drive(1, 3, 1); drive(1, 2, 1);
    rst = 1'b1; drive(0, 0, 1); rst = 1'b0;
    drive(1, 1, 1); drive(1, 3, 1); drive(1, 3, 1); drive(1, 2, 1);
    drive(0, 0, 1);

    // Reset while holding a result, with out_ready high in the same cycle
    drive(1, 2, 0); drive(1, 3, 0); drive(1, 1, 0); drive(1, 2, 0);
    drive(0, 0, 0);
    rst = 1'b1; drive(0, 0, 1); rst = 1'b0;
    check_reset_outputs("hold_reset");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
    end
    rst = 1'b0;

    // Drain anything left pending
    for (int i = 0; i < 3; i++) drive(0, 0, 1);
    check("min_queue_drained", exp_min.size(), 0);
    check("max_queue_drained", exp_max.size(), 0);

    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/minmax_stream_tracker.md
Name: minmax_stream_tracker

Overview:
- Sequential counterpart to the team's combinational 4-input min/max selector.
- Takes a frame of COUNT values serially over a valid/ready stream, one per accepted beat.
- Tracks the running minimum or maximum and its arrival index.
- Presents the winner and its index on a valid/ready output.
- Sits between a sample producer and any consumer that needs the extreme value of a frame plus its position.

Parameters:
- WIDTH, 2: bit width of each sample and of out_data.
- TYPE, "minsel": "minsel" selects the minimum; "maxsel" selects the maximum. Any other value behaves as "maxsel".
- COUNT, 4: samples per frame. Legal range is COUNT >= 2.
- IDXW, derived: equals $clog2(COUNT). Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_data.
- in_data  input  WIDTH  sample, unsigned.
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  result available.
- out_data  output  WIDTH  winning sample value.
- out_index  output  IDXW  zero-based frame position of the winning sample.
- out_ready  input  1  consumer takes the result.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_index=0, internal count=0, best=0, best_idx=0.
- Accept rule: a sample is accepted on any cycle with in_valid && in_ready.
- Output rule: a result is consumed on any cycle with out_valid && out_ready.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: best<=in_data, best_idx<=0, count<=1, go to ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On accept, compare in_data with best using a strict comparison: < for minsel, > for maxsel. If strictly better, best<=in_data and best_idx<=count. count<=count+1. When the accepted sample is number COUNT (count==COUNT-1 before the update), go to HOLD; the comparison result for that sample is included. No accept means no state change; gaps in in_valid are legal.
  - HOLD: in_ready=0, out_valid=1, out_data=best, out_index=best_idx. Outputs stay stable until consumed. On consume, go to IDLE and clear count.
- Output timing: out_data and out_index are registered. Latency from acceptance of the last sample to out_valid=1 is one cycle.
- Throughput: no overlap between frames. While in HOLD, in_ready=0 and producer samples are not accepted. Maximum rate is one frame per COUNT+1 cycles when out_ready is held high.
- Ties: the earliest index is kept. A later equal value never replaces best unless the optional feature is compiled in.
- Arithmetic: all comparisons are unsigned at WIDTH bits. The count register is wide enough to hold COUNT-1 and never wraps inside a frame.
- Reset mid-frame or in HOLD: the partial frame or pending result is discarded. All outputs return to reset values on the next edge. Reset has priority over accept and consume in the same cycle.
- out_ready asserted outside HOLD has no effect.
- in_data is ignored when in_valid=0.

Optional Feature:
- Macro: MINMAX_TIE_LAST_EN.
- Defined: comparisons become non-strict (<= for minsel, >= for maxsel) for samples after the first. An equal value replaces best, so out_index reports the latest position of the extreme value.
- Undefined: strict comparison; out_index reports the earliest position.
- Defining the macro does not change ports, latency or handshake.

Test Plan:
- Defaults, minsel, out_ready=1: stream 3,1,2,0 on consecutive cycles -> one cycle after the 4th accept, out_valid=1, out_data=0, out_index=3. Next cycle out_valid=0 and in_ready=1.
- TYPE="maxsel": stream 1,3,0,3 -> out_data=3, out_index=1. With MINMAX_TIE_LAST_EN defined -> out_data=3, out_index=3.
- Gapped input, minsel: in_valid pattern 1,0,0,1,0,1,1 with data 2,x,x,2,x,3,1 -> result out_data=1, out_index=3. Dropped beats must not advance the count.
- Backpressure: finish a frame with out_ready=0 for 5 cycles -> out_valid held at 1, out_data/out_index stable, in_ready=0 while in_valid=1. Raise out_ready -> consumed in 1 cycle. The next frame 0,0,0,0 gives out_data=0, out_index=0.
- Reset mid-frame: accept 3,2, then pulse rst for 1 cycle, then stream 1,3,3,2 -> minsel result out_data=1, out_index=0. The pre-reset samples have no effect.
- Reset in HOLD with out_ready=1 in the same cycle -> next cycle out_valid=0, out_data=0, out_index=0, in_ready=1.
